// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared widths, constants and entry type for the fetch queue
package fetch_pkg;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] RESET_PC = '0;
  localparam logic [AW-1:0] PC_INC = AW'(4);

  // One queue slot: PC is written when the slot is reserved, instr on response
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          filled;
  } entry_t;

endpackage

// File: rtl/fq_ptr_ctrl.sv
// rtl/fq_ptr_ctrl.sv - tail/fill/head pointers, reservation and drop counters for the fetch queue
module fq_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic                       grant,
  input  logic                       rvalid,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   head,
  output logic [$clog2(DEPTH)-1:0]   tail,
  output logic [$clog2(DEPTH)-1:0]   fill,
  output logic                       fill_en,
  output logic                       full,
  output logic                       empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  // In-flight stale responses can exceed DEPTH after repeated redirects
  localparam int DCW = CW + 3;

  logic [CW-1:0]  alloc_cnt;
  logic [CW-1:0]  pend_cnt;
  logic [DCW-1:0] drop_cnt;

  // A response is kept only once every stale in-flight response has been discarded
  assign fill_en = rvalid && (drop_cnt == '0);
  assign full    = (alloc_cnt == CW'(DEPTH));
  assign empty   = (alloc_cnt == '0);

  // Pointer and counter update; redirect flushes and converts pending slots into drops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= '0;
    end else if (redirect) begin
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      pend_cnt  <= '0;
      drop_cnt  <= drop_cnt + DCW'(pend_cnt) - DCW'(rvalid);
    end else begin
      if (grant)   tail <= tail + PW'(1);
      if (fill_en) fill <= fill + PW'(1);
      if (pop)     head <= head + PW'(1);
      alloc_cnt <= alloc_cnt + CW'(grant) - CW'(pop);
      pend_cnt  <= pend_cnt + CW'(grant) - CW'(fill_en);
      if (rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - DCW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue feeding IF/ID; optional FETCH_BYPASS_EN same-cycle response bypass
module fetch_queue #(
  parameter int AW = fetch_pkg::AW,
  parameter int DW = fetch_pkg::DW,
  parameter int DEPTH = 4,
  parameter logic [AW-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [DW-1:0] imem_rdata,
  output logic          out_valid,
  output logic [AW-1:0] out_pc,
  output logic [DW-1:0] out_instr,
  input  logic          out_ready
);
  import fetch_pkg::*;

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head, tail, fill;
  logic          fill_en, full, empty;
  logic          grant, pop, bypass;
  logic [AW-1:0] fetch_pc, hold_pc;
  logic [DW-1:0] hold_instr;
  entry_t        q [DEPTH];

  // Request is gated by reset so the port reads idle while rst is asserted
  assign imem_req  = rst && !redirect && !full;
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;
  assign pop       = out_valid && out_ready;

`ifdef FETCH_BYPASS_EN
  // Head slot is the one being filled right now: forward the response directly
  assign bypass = !redirect && fill_en && !empty && (head == fill) && !q[head].filled;
`else
  assign bypass = 1'b0;
`endif

  fq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .redirect (redirect),
    .grant    (grant),
    .rvalid   (imem_rvalid),
    .pop      (pop),
    .head     (head),
    .tail     (tail),
    .fill     (fill),
    .fill_en  (fill_en),
    .full     (full),
    .empty    (empty)
  );

  // Head presentation; with nothing to show, the last presented pair is held
  always_comb begin
    out_valid = 1'b0;
    out_pc    = hold_pc;
    out_instr = hold_instr;
    if (!redirect && !empty && (q[head].filled || bypass)) begin
      out_valid = 1'b1;
      out_pc    = q[head].pc;
      out_instr = bypass ? imem_rdata : q[head].instr;
    end
  end

  // Slot storage: reserve on grant, fill on response, retire on pop; redirect invalidates all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (redirect) begin
      for (int i = 0; i < DEPTH; i++) q[i].filled <= 1'b0;
    end else begin
      if (grant) q[tail].pc <= fetch_pc;
      if (fill_en) begin
        q[fill].instr  <= imem_rdata;
        q[fill].filled <= 1'b1;
      end
      // Placed after the fill so a bypassed-and-popped slot ends up empty
      if (pop) q[head].filled <= 1'b0;
    end
  end

  // Sequential fetch address, restarted by redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_pc;
    else if (grant)    fetch_pc <= fetch_pc + PC_INC;
  end

  // Remember the last presented pair for display while the queue is empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (out_valid) begin
      hold_pc    <= out_pc;
      hold_instr <= out_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam int FILL_LAT = 1;
`else
  localparam int FILL_LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [DW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic [AW-1:0] out_pc;
  logic [DW-1:0] out_instr;
  logic          out_ready = 1'b0;

  fetch_queue #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: PCs fetched since last flush and not yet consumed, next expected fetch PC,
  // and the memory's in-order response queue (address, earliest response cycle)
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] mem_addr_q[$];
  int            mem_rdy_q[$];
  logic [AW-1:0] nxt_pc = RESET_PC;
  int cyc = 0, last_rdy = 0;
  int gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
  int grants = 0, first_gnt = -1, first_val = -1;
  logic done = 1'b0;
  logic [AW-1:0] exp_pc;
  logic [AW-1:0] rp;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, then settle and update the reference for the coming edge
  task automatic step(input logic do_redir, input logic [AW-1:0] rpc);
    int lat;
    @(negedge clk);
    redirect    = do_redir;
    redirect_pc = rpc;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    out_ready   = ($urandom_range(99) < ready_pct);
    if (mem_rdy_q.size() > 0 && mem_rdy_q[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    check("imem_req", imem_req, !do_redir && (exp_q.size() < DEPTH));
    if (out_valid && first_val < 0) first_val = cyc;
    if (do_redir) begin
      exp_q.delete();
      nxt_pc = rpc;
    end else if (imem_req) begin
      check("imem_addr", imem_addr, nxt_pc);
      if (imem_gnt) begin
        exp_q.push_back(nxt_pc);
        lat = $urandom_range(lat_max, lat_min);
        last_rdy = (cyc + lat > last_rdy) ? cyc + lat : last_rdy;
        mem_addr_q.push_back(nxt_pc);
        mem_rdy_q.push_back(last_rdy);
        nxt_pc = nxt_pc + 32'd4;
        grants++;
        if (first_gnt < 0) first_gnt = cyc;
      end
    end
    if (imem_rvalid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_rdy_q.pop_front());
    end
    cyc++;
  endtask

  // Asynchronous reset in mid-cycle; memory is reset along with the queue
  task automatic do_reset(input int hold);
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    exp_q.delete();
    mem_addr_q.delete();
    mem_rdy_q.delete();
    nxt_pc = RESET_PC;
    last_rdy = 0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    redirect = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: whenever the DUT hands an instruction over, compare it with the oldest expected PC
  initial begin
    while (!done) begin
      @(negedge clk);
      #2;
      if (redirect) check("redirect_out_valid", out_valid, 1'b0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got pc %0h, expected no output", out_pc);
        end else begin
          exp_pc = exp_q.pop_front();
          check("out_pc", out_pc, exp_pc);
          check("out_instr", out_instr, mem_word(exp_pc));
        end
      end
    end
  end

  initial begin
    #1;
    check("init_out_valid", out_valid, 1'b0);
    check("init_imem_req", imem_req, 1'b0);
    check("init_out_pc", out_pc, 0);
    check("init_out_instr", out_instr, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Streaming with 1-cycle memory and a never-stalling IF/ID
    repeat (20) step(1'b0, '0);
    check("fill_latency", first_val - first_gnt, FILL_LAT);

    // Stall so entries are buffered, then reset mid-stream
    ready_pct = 0;
    repeat (3) step(1'b0, '0);
    check("pre_reset_valid", out_valid, 1'b1);
    do_reset(2);

    // IF/ID stalled for 10 cycles: exactly DEPTH grants, then release
    grants = 0;
    repeat (10) step(1'b0, '0);
    check("stall_grants", grants, DEPTH);
    ready_pct = 100;
    repeat (12) step(1'b0, '0);

    // Redirect with three responses in flight
    lat_min = 3; lat_max = 3;
    repeat (8) step(1'b0, '0);
    step(1'b1, 32'h0000_0100);
    repeat (15) step(1'b0, '0);

    // Redirect while pops and responses occur every cycle, including back-to-back redirects
    lat_min = 1; lat_max = 1;
    repeat (8) step(1'b0, '0);
    step(1'b1, 32'h0000_0200);
    repeat (4) step(1'b0, '0);
    step(1'b1, 32'h0000_0300);
    step(1'b1, 32'h0000_0400);
    repeat (12) step(1'b0, '0);

    // Randomized grant, latency, stall and redirect
    gnt_pct = 70; ready_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1000; i++) begin
      rp = $urandom & 32'h0000_fffc;
      step($urandom_range(99) < 3, rp);
    end

    // Drain: every fetched PC since the last flush must have been delivered
    gnt_pct = 0; ready_pct = 100;
    repeat (20) step(1'b0, '0);
    check("drain_empty", exp_q.size(), 0);

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
